// File: rtl/kd_node_sorter_pkg.sv
// kd_pkg: shared widths, FSM state encoding and the coordinate-extract helper
// used by kd_node_sorter and kd_cmp_swap.
//   dim_size(range)         bits per coordinate
//   center_size(dim, range) bits per packed center
//   axis_size(dim)          bits needed to name an axis (at least 1)
//   cnt_size(n)             bits for a phase count of 0..n
//   coord_key(c, axis, dsz) coordinate 'axis' of center c, zero-extended
package kd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SORT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Upper bounds for the generic helper; callers zero-extend into these.
    localparam int KEY_MAX_W    = 32;
    localparam int CENTER_MAX_W = 1024;

    function automatic int dim_size(int range);
        return $clog2(range);
    endfunction

    function automatic int center_size(int dim, int range);
        return dim * dim_size(range);
    endfunction

    function automatic int axis_size(int dim);
        return ($clog2(dim) < 1) ? 1 : $clog2(dim);
    endfunction

    function automatic int cnt_size(int n);
        return $clog2(n + 1);
    endfunction

    function automatic logic [KEY_MAX_W-1:0] coord_key(
        logic [CENTER_MAX_W-1:0] c, int axis, int dsz);
        logic [CENTER_MAX_W-1:0] sh;
        logic [KEY_MAX_W-1:0]    mask;
        sh   = c >> (axis * dsz);
        mask = ~({KEY_MAX_W{1'b1}} << dsz);
        return sh[KEY_MAX_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/kd_node_sorter_if.sv
// kd_node_sorter_if: request/response bundle of the kd-tree center sorter.
//   master: requester (drives start, axis, desc, centers_in)
//   slave : sorter    (drives ready, busy, done and all results)
interface kd_node_sorter_if
    import kd_pkg::*;
#(
    parameter int DIM         = 3,
    parameter int DATA_RANGE  = 255,
    parameter int NUM_CENTERS = 4
);
    localparam int CW   = center_size(DIM, DATA_RANGE);
    localparam int AW   = axis_size(DIM);
    localparam int CNTW = cnt_size(NUM_CENTERS);

    logic                      start;
    logic                      ready;
    logic                      busy;
    logic [AW-1:0]             axis;
    logic                      desc;
    logic [NUM_CENTERS*CW-1:0] centers_in;
    logic [NUM_CENTERS*CW-1:0] centers_out;
    logic [CW-1:0]             median;
    logic [AW-1:0]             child_axis;
    logic [CNTW-1:0]           phases_used;
    logic                      axis_err;
    logic                      done;

    modport master (
        output start, axis, desc, centers_in,
        input  ready, busy, centers_out, median, child_axis,
               phases_used, axis_err, done
    );

    modport slave (
        input  start, axis, desc, centers_in,
        output ready, busy, centers_out, median, child_axis,
               phases_used, axis_err, done
    );
endinterface

// File: rtl/kd_node_sorter_cmp_swap.sv
// kd_cmp_swap: combinational compare-exchange of two packed centers.
//   a, b     centers at the lower / upper index of the pair
//   axis     coordinate used as key; desc selects descending order
//   en       pair is active this phase (0 passes a/b through)
//   lo, hi   centers to write back to the lower / upper index
//   swapped  pair was exchanged
module kd_cmp_swap
    import kd_pkg::*;
#(
    parameter int DIM        = 3,
    parameter int DATA_RANGE = 255
) (
    input  logic [center_size(DIM, DATA_RANGE)-1:0] a,
    input  logic [center_size(DIM, DATA_RANGE)-1:0] b,
    input  logic [axis_size(DIM)-1:0]               axis,
    input  logic                                    desc,
    input  logic                                    en,
    output logic [center_size(DIM, DATA_RANGE)-1:0] lo,
    output logic [center_size(DIM, DATA_RANGE)-1:0] hi,
    output logic                                    swapped
);
    localparam int DS = dim_size(DATA_RANGE);

    logic [KEY_MAX_W-1:0] key_a, key_b;

    assign key_a = coord_key(CENTER_MAX_W'(a), int'(axis), DS);
    assign key_b = coord_key(CENTER_MAX_W'(b), int'(axis), DS);

    // Strict compare: equal keys stay put, which keeps the sort stable.
    assign swapped = en && (desc ? (key_a < key_b) : (key_a > key_b));
    assign lo      = swapped ? b : a;
    assign hi      = swapped ? a : b;
endmodule

// File: rtl/kd_node_sorter.sv
// kd_node_sorter: odd-even transposition sorter for kd-tree cluster centers.
//   clk, rst  clock, synchronous active-high reset
//   bus       kd_node_sorter_if.slave: start/ready/busy handshake, axis,
//             desc, centers_in in; centers_out, median, child_axis,
//             phases_used, axis_err, done out
// One phase per SORT cycle; leaves SORT after two zero-swap phases in a row
// or after NUM_CENTERS phases, then spends one DONE cycle with done=1.
module kd_node_sorter
    import kd_pkg::*;
#(
    parameter int DIM         = 3,
    parameter int DATA_RANGE  = 255,
    parameter int NUM_CENTERS = 4
) (
    input  logic             clk,
    input  logic             rst,
    kd_node_sorter_if.slave  bus
);
    localparam int N    = NUM_CENTERS;
    localparam int CW   = center_size(DIM, DATA_RANGE);
    localparam int AW   = axis_size(DIM);
    localparam int CNTW = cnt_size(N);
    localparam int NP   = N / 2;
    localparam int MED  = (N - 1) / 2;

    state_e                 state;
    logic [N-1:0][CW-1:0]   work, nxt;
    logic [AW-1:0]          axis_q;
    logic                   desc_q;
    logic [CNTW-1:0]        phase_cnt;
    logic                   parity;      // 0 = even phase
    logic                   prev_zero;   // previous phase had no swaps

    logic                   ready_q, busy_q, done_q, axis_err_q;
    logic [AW-1:0]          child_q;
    logic [N*CW-1:0]        out_q;
    logic [CW-1:0]          median_q;
    logic [CNTW-1:0]        phases_q;

    logic [NP-1:0][CW-1:0]  lo, hi;
    logic [NP-1:0]          swp;

    // Comparator p serves pair (2p,2p+1) on even phases and (2p+1,2p+2) on
    // odd phases; the last comparator idles on odd phases when N is even.
    for (genvar p = 0; p < NP; p++) begin : g_pair
        logic [CW-1:0] a_o, b_o;
        logic          odd_ok;
        if (2*p + 2 < N) begin : g_odd
            assign a_o    = work[2*p+1];
            assign b_o    = work[2*p+2];
            assign odd_ok = 1'b1;
        end else begin : g_no_odd
            assign a_o    = work[2*p];
            assign b_o    = work[2*p+1];
            assign odd_ok = 1'b0;
        end

        kd_cmp_swap #(.DIM(DIM), .DATA_RANGE(DATA_RANGE)) u_cmp (
            .a       (parity ? a_o : work[2*p]),
            .b       (parity ? b_o : work[2*p+1]),
            .axis    (axis_q),
            .desc    (desc_q),
            .en      (parity ? odd_ok : 1'b1),
            .lo      (lo[p]),
            .hi      (hi[p]),
            .swapped (swp[p])
        );
    end

    // Route comparator results back to their element slots for each parity.
    for (genvar i = 0; i < N; i++) begin : g_elem
        logic [CW-1:0] ev, od;
        if (i / 2 < NP) begin : g_ev
            if (i % 2 == 0) begin : g_l
                assign ev = lo[i/2];
            end else begin : g_h
                assign ev = hi[i/2];
            end
        end else begin : g_ev_pass
            assign ev = work[i];
        end
        if (i == 0) begin : g_od_first
            assign od = work[0];
        end else if (i % 2 == 1) begin : g_od_lo
            if (i + 1 < N) begin : g_l
                assign od = lo[(i-1)/2];
            end else begin : g_pass
                assign od = work[i];
            end
        end else begin : g_od_hi
            assign od = hi[(i-2)/2];
        end
        assign nxt[i] = parity ? od : ev;
    end

    logic            any_swap, sort_exit, axis_ok;
    logic [CNTW-1:0] phase_nxt;
    logic [AW-1:0]   eff_axis;

    assign any_swap  = |swp;
    assign phase_nxt = phase_cnt + CNTW'(1);
    assign sort_exit = (!any_swap && prev_zero) || (phase_nxt == CNTW'(N));
    assign axis_ok   = int'(bus.axis) < DIM;
    assign eff_axis  = axis_ok ? bus.axis : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            work       <= '0;
            axis_q     <= '0;
            desc_q     <= 1'b0;
            phase_cnt  <= '0;
            parity     <= 1'b0;
            prev_zero  <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            axis_err_q <= 1'b0;
            child_q    <= '0;
            out_q      <= '0;
            median_q   <= '0;
            phases_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        work       <= bus.centers_in;
                        axis_q     <= eff_axis;
                        desc_q     <= bus.desc;
                        axis_err_q <= !axis_ok;
                        child_q    <= AW'((int'(eff_axis) + 1) % DIM);
                        phase_cnt  <= '0;
                        parity     <= 1'b0;
                        prev_zero  <= 1'b0;
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= ST_SORT;
                    end
                end
                ST_SORT: begin
                    work      <= nxt;
                    parity    <= !parity;
                    phase_cnt <= phase_nxt;
                    prev_zero <= !any_swap;
                    if (sort_exit) begin
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        out_q    <= nxt;
                        median_q <= nxt[MED];
                        phases_q <= phase_nxt;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ready       = ready_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.axis_err    = axis_err_q;
    assign bus.child_axis  = child_q;
    assign bus.centers_out = out_q;
    assign bus.median      = median_q;
    assign bus.phases_used = phases_q;
endmodule

// File: tb/tb_kd_node_sorter.sv
module tb_kd_node_sorter;
    localparam int DIM = 3, DR = 255, N = 4, CW = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    kd_node_sorter_if #(.DIM(DIM), .DATA_RANGE(DR), .NUM_CENTERS(N)) bus ();
    kd_node_sorter #(.DIM(DIM), .DATA_RANGE(DR), .NUM_CENTERS(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0, failures = 0;

    typedef struct {
        logic [1:0]      ax;
        logic            ds;
        logic [N*CW-1:0] cin;
        logic [N*CW-1:0] cout;
        int              k;
        logic            err;
        logic [1:0]      child;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] mk(input int x, input int y, input int z);
        return {z[7:0], y[7:0], x[7:0]};
    endfunction

    function automatic logic [N*CW-1:0] pk(input logic [CW-1:0] c0, c1, c2, c3);
        return {c3, c2, c1, c0};
    endfunction

    // Out-of-order test for a (lower index) vs b under the chosen order.
    function automatic bit ooo(input int ka, input int kb, input logic ds);
        return ds ? (ka < kb) : (ka > kb);
    endfunction

    // Reference: stable insertion sort gives the order; a phase-by-phase
    // transposition count gives the number of phases before exit.
    task automatic model(input logic [1:0] ax, input logic ds, input logic [N*CW-1:0] cin,
                         output logic [N*CW-1:0] cout, output int k,
                         output logic err, output logic [1:0] child);
        logic [CW-1:0] c[N];
        logic [CW-1:0] t;
        int key[N];
        int ea, zeros, s, tk;
        err   = (ax >= 2'd3);
        ea    = err ? 0 : int'(ax);
        child = 2'((ea + 1) % DIM);
        for (int i = 0; i < N; i++) c[i] = cin[i*CW +: CW];
        for (int i = 1; i < N; i++)
            for (int j = i; j > 0; j--)
                if (ooo(int'(c[j-1][ea*8 +: 8]), int'(c[j][ea*8 +: 8]), ds)) begin
                    t = c[j]; c[j] = c[j-1]; c[j-1] = t;
                end
        cout = '0;
        for (int i = 0; i < N; i++) cout[i*CW +: CW] = c[i];
        for (int i = 0; i < N; i++) key[i] = int'(cin[i*CW + ea*8 +: 8]);
        k = 0; zeros = 0;
        while (1) begin
            s = 0;
            for (int i = k % 2; i + 1 < N; i += 2)
                if (ooo(key[i], key[i+1], ds)) begin
                    tk = key[i]; key[i] = key[i+1]; key[i+1] = tk; s++;
                end
            k++;
            zeros = (s == 0) ? zeros + 1 : 0;
            if (zeros >= 2 || k == N) break;
        end
    endtask

    // Drive one request at a negedge and check latency and all results.
    task automatic run_op(input string tag, input logic [1:0] ax, input logic ds,
                          input logic [N*CW-1:0] cin, input logic [N*CW-1:0] cout,
                          input int k, input logic err, input logic [1:0] child);
        int n;
        bit got;
        @(negedge clk);
        bus.start = 1'b1; bus.axis = ax; bus.desc = ds; bus.centers_in = cin;
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, ".busy"}, 128'(bus.busy), 128'(1));
        n = 1; got = 0;
        while (n <= 12 && !got) begin
            if (bus.done === 1'b1) got = 1;
            else begin @(negedge clk); n++; end
        end
        if (!got) begin
            chk({tag, ".timeout"}, 128'(0), 128'(1));
        end else begin
            chk({tag, ".latency"}, 128'(n), 128'(k + 1));
            chk({tag, ".centers"}, 128'(bus.centers_out), 128'(cout));
            chk({tag, ".median"}, 128'(bus.median), 128'(cout[CW +: CW]));
            chk({tag, ".phases"}, 128'(bus.phases_used), 128'(k));
            chk({tag, ".axis_err"}, 128'(bus.axis_err), 128'(err));
            chk({tag, ".child"}, 128'(bus.child_axis), 128'(child));
            @(negedge clk);
            chk({tag, ".done_pulse"}, 128'(bus.done), 128'(0));
            chk({tag, ".ready_after"}, 128'(bus.ready), 128'(1));
            chk({tag, ".hold"}, 128'(bus.centers_out), 128'(cout));
        end
    endtask

    logic [N*CW-1:0] rc, rout;
    int rk, dones;
    logic rerr;
    logic [1:0] rch, rax;
    logic rds;
    bit ready_early;

    initial begin
        bus.start = 1'b0; bus.axis = '0; bus.desc = 1'b0; bus.centers_in = '0;

        tbl[0] = '{2'd0, 1'b0, pk(mk(40,0,0), mk(10,0,0), mk(30,0,0), mk(20,0,0)),
                   pk(mk(10,0,0), mk(20,0,0), mk(30,0,0), mk(40,0,0)), 4, 1'b0, 2'd1};
        tbl[1] = '{2'd1, 1'b0, pk(mk(0,5,0), mk(0,6,0), mk(0,7,0), mk(0,8,0)),
                   pk(mk(0,5,0), mk(0,6,0), mk(0,7,0), mk(0,8,0)), 2, 1'b0, 2'd2};
        tbl[2] = '{2'd2, 1'b1, pk(mk(1,0,9), mk(2,0,3), mk(3,0,9), mk(4,0,3)),
                   pk(mk(1,0,9), mk(3,0,9), mk(2,0,3), mk(4,0,3)), 4, 1'b0, 2'd0};
        tbl[3] = '{2'd3, 1'b0, pk(mk(4,0,0), mk(3,0,0), mk(2,0,0), mk(1,0,0)),
                   pk(mk(1,0,0), mk(2,0,0), mk(3,0,0), mk(4,0,0)), 4, 1'b1, 2'd1};

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst.ready", 128'(bus.ready), 128'(1));
        chk("rst.busy", 128'(bus.busy), 128'(0));
        chk("rst.done", 128'(bus.done), 128'(0));
        chk("rst.centers", 128'(bus.centers_out), 128'(0));
        chk("rst.phases", 128'(bus.phases_used), 128'(0));
        chk("rst.err_child", 128'({bus.axis_err, bus.child_axis}), 128'(0));

        for (int i = 0; i < 4; i++)
            run_op($sformatf("vec%0d", i), tbl[i].ax, tbl[i].ds, tbl[i].cin,
                   tbl[i].cout, tbl[i].k, tbl[i].err, tbl[i].child);

        // Handshake: start pulsed during SORT is ignored
        @(negedge clk);
        bus.start = 1'b1; bus.axis = tbl[0].ax; bus.desc = 1'b0; bus.centers_in = tbl[0].cin;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.axis = 2'd2; bus.centers_in = tbl[1].cin;
        @(negedge clk);
        bus.start = 1'b0;
        dones = 0; ready_early = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus.done === 1'b1) begin
                dones++;
                chk("hs.centers", 128'(bus.centers_out), 128'(tbl[0].cout));
            end
            if (dones == 0 && bus.ready === 1'b1) ready_early = 1;
            @(negedge clk);
        end
        chk("hs.done_count", 128'(dones), 128'(1));
        chk("hs.ready_low", 128'(ready_early), 128'(0));
        run_op("hs.axis2", 2'd2, 1'b0, tbl[1].cin, tbl[1].cin, 2, 1'b0, 2'd0);

        // Reset mid-sort during phase 2
        @(negedge clk);
        bus.start = 1'b1; bus.axis = 2'd0; bus.desc = 1'b0; bus.centers_in = tbl[0].cin;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst.ready", 128'(bus.ready), 128'(1));
        chk("mrst.busy", 128'(bus.busy), 128'(0));
        chk("mrst.done", 128'(bus.done), 128'(0));
        chk("mrst.centers", 128'(bus.centers_out), 128'(0));
        dones = 0;
        for (int c = 0; c < 8; c++) begin
            if (bus.done === 1'b1) dones++;
            @(negedge clk);
        end
        chk("mrst.no_done", 128'(dones), 128'(0));
        run_op("mrst.after", tbl[3].ax, tbl[3].ds, tbl[3].cin,
               tbl[3].cout, tbl[3].k, tbl[3].err, tbl[3].child);

        // Randomized against the reference model; narrow keys force ties.
        for (int r = 0; r < 40; r++) begin
            rax = 2'($urandom_range(0, 3));
            rds = 1'($urandom_range(0, 1));
            for (int i = 0; i < N; i++)
                rc[i*CW +: CW] = mk($urandom_range(0, 7), $urandom_range(0, 7),
                                    $urandom_range(0, 255));
            model(rax, rds, rc, rout, rk, rerr, rch);
            run_op($sformatf("rnd%0d", r), rax, rds, rc, rout, rk, rerr, rch);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/kd_node_sorter.md
Name: kd_node_sorter

Overview:
Multi-cycle, parametrised sort engine for kd-tree cluster centers.
- Sorts NUM_CENTERS packed centers by their coordinate on a selectable split axis, ascending or descending.
- Uses odd-even transposition sort with early exit, and reports the median center and the next-level split axis.
- Sits between center-update logic and kd-tree node construction. It replaces single three-way compare-exchange with an N-wide, handshaked sequential sorter.

Parameters:
- DIM, 3, coordinates per center.
- DATA_RANGE, 255, maximum coordinate value.
- NUM_CENTERS, 4, centers per sort (>=2).

Derived widths:
- dim_size = $clog2(DATA_RANGE)
- center_size = DIM*dim_size
- axis_size = max(1,$clog2(DIM))
- cnt_size = $clog2(NUM_CENTERS+1)

Ports:
- clk  in  1  clock
- rst  in  1  reset; see Behaviour
- start  in  1  request; accepted only when ready=1
- ready  out  1  high in IDLE
- busy  out  1  high in SORT
- axis  in  axis_size  split axis, sampled on accept
- desc  in  1  1 = descending order, sampled on accept
- centers_in  in  NUM_CENTERS*center_size  packed centers, sampled on accept
- centers_out  out  NUM_CENTERS*center_size  sorted centers
- median  out  center_size  centers_out entry at index (NUM_CENTERS-1)/2
- child_axis  out  axis_size  (effective axis+1) mod DIM
- phases_used  out  cnt_size  sort phases executed
- axis_err  out  1  sampled axis was >= DIM
- done  out  1  one-cycle completion pulse

Behaviour:
- Single clock clk. Reset rst is synchronous, active-high.
- Reset values: state IDLE; ready=1; all other outputs 0.
- Reset mid-sort aborts the operation. The next cycle is IDLE with all outputs cleared and no done pulse.
- Packing:
  - center i occupies bits [i*center_size +: center_size];
  - coordinate d occupies bits [d*dim_size +: dim_size] within a center (dim 0 in LSBs).
- States: IDLE -> SORT -> DONE -> IDLE.
- IDLE:
  - On start=1, the same edge latches centers_in into the working array, and latches axis and desc.
  - phase counter=0, parity=even; go to SORT.
  - If axis >= DIM, axis_err=1 and the effective axis is 0; otherwise axis_err=0.
  - axis_err and child_axis update on accept and hold until the next accept.
- SORT: one phase per cycle.
  - Even phase compares pairs (0,1),(2,3),...; odd phase compares pairs (1,2),(3,4),...
  - A pair (a at lower index, b) swaps iff key(a) > key(b) when ascending, or key(a) < key(b) when descending. key is the coordinate on the effective axis.
  - Compare is strict, so equal keys never swap and the sort is stable.
  - Keys compare as unsigned dim_size values. Whole centers move, not only keys.
  - Each phase flips parity and increments the phase counter.
- Exit SORT to DONE after the phase where either:
  - two consecutive phases produced zero swaps, or
  - phase counter reaches NUM_CENTERS (the guaranteed bound).
  - An odd phase with no pairs (NUM_CENTERS=2) counts as a zero-swap phase.
- DONE (exactly one cycle):
  - done=1.
  - centers_out, median and phases_used are registered from the working array and counter, and are valid from this cycle.
  - They hold until the next accept.
  - Next state IDLE.
- start is ignored while busy or done is high; no queueing.
- Latency from the accept edge: done is high k+1 cycles later, where k=phases_used, 2<=k<=NUM_CENTERS.
- start held high continuously restarts on each IDLE cycle.

Decomposition:
- Shared package kd_pkg holds:
  - width functions (dim_size, center_size, axis_size);
  - state encoding (IDLE/SORT/DONE);
  - a coord-extract function (center, axis) -> key.
- Sub-module kd_cmp_swap:
  - inputs: a, b, axis, desc, en;
  - outputs: lo, hi, swapped;
  - purely combinational; instanced floor(NUM_CENTERS/2) times and re-muxed for odd/even phase.
- Top holds the FSM, counters and registers.

Test Plan:
Test configuration is DIM=3, DATA_RANGE=255, NUM_CENTERS=4; centers are written (x,y,z), listed from index 0.
- Ascending x sort: axis=0, desc=0, x keys 40,10,30,20 (y=z=0) -> centers_out x = 10,20,30,40; phases_used=4; median x=20; child_axis=1; done exactly 5 cycles after accept.
- Early exit: axis=1, input y = 5,6,7,8 already sorted -> unchanged output; phases_used=2; done 3 cycles after accept.
- Stability and descending order: axis=2, desc=1, centers (1,0,9),(2,0,3),(3,0,9),(4,0,3) -> output order (1,0,9),(3,0,9),(2,0,3),(4,0,3); child_axis=0.
- Axis error: axis=3, x keys 4,3,2,1 -> axis_err=1; sorted on x to 1,2,3,4; child_axis=1.
- Handshake: start pulsed during SORT -> ignored, exactly one done pulse, ready low until the cycle after done. Then start with axis=2 accepted in IDLE, and axis_err returns to 0.
- Reset mid-sort: rst for 1 cycle during phase 2 -> next cycle ready=1, busy=0, done=0, centers_out=0, no done pulse. A subsequent start sorts correctly.
